// File: rtl/rv_decode_stage_if.sv
// rtl/rv_decode_stage_if.sv - fetch-side and execute-side signals of the RV32I decode stage
interface rv_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [XLEN-1:0]  pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic [XLEN-1:0]  out_imm;
  logic [3:0]       out_alu_control;
  logic             out_alu_src;
  logic             out_reg_write;
  logic             out_mem_read;
  logic             out_mem_write;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_count;

  // master: the fetch/execute environment around the stage; slave: the stage itself
  modport master (
    output in_valid, instr, pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
    input  out_alu_control, out_alu_src, out_reg_write, out_mem_read,
    input  out_mem_write, out_illegal, illegal_count
  );

  modport slave (
    input  in_valid, instr, pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
    output out_alu_control, out_alu_src, out_reg_write, out_mem_read,
    output out_mem_write, out_illegal, illegal_count
  );
endinterface

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - registered RV32I decode/control stage with illegal-instruction counting
module rv_decode_stage #(
  parameter int XLEN       = 32,
  parameter int ENABLE_SLT = 1,
  parameter int CNT_W      = 16
) (
  input logic               clk,
  input logic               rst,
  rv_decode_stage_if.slave  bus
);
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic       SLT_ON   = (ENABLE_SLT != 0);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_sh;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];

  // replication counts stay >= 1 for XLEN == 32 by splitting the sign bit off the field
  assign imm_i  = {{(XLEN-11){bus.instr[31]}}, bus.instr[30:20]};
  assign imm_s  = {{(XLEN-11){bus.instr[31]}}, bus.instr[30:25], bus.instr[11:7]};
  assign imm_u  = {{(XLEN-31){bus.instr[31]}}, bus.instr[30:12], 12'b0};
  assign imm_sh = {{(XLEN-5){1'b0}}, bus.instr[24:20]};

  logic            dec_ill, dec_src, dec_rw, dec_mr, dec_mw;
  logic [3:0]      dec_alu;
  logic [4:0]      dec_rs1;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    dec_ill = 1'b0;
    dec_src = 1'b0;
    dec_rw  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_alu = ALU_ADD;
    dec_imm = '0;
    dec_rs1 = bus.instr[19:15];
    case (opcode)
      OP_R: begin
        dec_rw = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: dec_alu = ALU_ADD;
          10'b0100000_000: dec_alu = ALU_SUB;
          10'b0000000_111: dec_alu = ALU_AND;
          10'b0000000_110: dec_alu = ALU_OR;
          10'b0000000_100: dec_alu = ALU_XOR;
          10'b0000000_001: dec_alu = ALU_SLL;
          10'b0000000_101: dec_alu = ALU_SRL;
          10'b0100000_101: dec_alu = ALU_SRA;
          10'b0000000_010: begin dec_alu = ALU_SLT;  dec_ill = !SLT_ON; end
          10'b0000000_011: begin dec_alu = ALU_SLTU; dec_ill = !SLT_ON; end
          default:         dec_ill = 1'b1;
        endcase
      end
      OP_I: begin
        dec_src = 1'b1;
        dec_rw  = 1'b1;
        dec_imm = imm_i;
        case (funct3)
          3'b000: dec_alu = ALU_ADD;
          3'b100: dec_alu = ALU_XOR;
          3'b110: dec_alu = ALU_OR;
          3'b111: dec_alu = ALU_AND;
          3'b010: begin dec_alu = ALU_SLT;  dec_ill = !SLT_ON; end
          3'b011: begin dec_alu = ALU_SLTU; dec_ill = !SLT_ON; end
          3'b001: begin
            dec_imm = imm_sh;
            dec_alu = ALU_SLL;
            dec_ill = (funct7 != 7'b0000000);
          end
          default: begin
            dec_imm = imm_sh;
            dec_alu = funct7[5] ? ALU_SRA : ALU_SRL;
            dec_ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          end
        endcase
      end
      OP_LOAD: begin
        dec_src = 1'b1;
        dec_rw  = 1'b1;
        dec_mr  = 1'b1;
        dec_imm = imm_i;
        dec_ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        dec_src = 1'b1;
        dec_mw  = 1'b1;
        dec_imm = imm_s;
        dec_ill = funct3[2] || (funct3 == 3'b011);
      end
      OP_LUI: begin
        dec_src = 1'b1;
        dec_rw  = 1'b1;
        dec_imm = imm_u;
        dec_rs1 = 5'd0;
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_rw  = 1'b0;
      dec_mr  = 1'b0;
      dec_mw  = 1'b0;
      dec_alu = ALU_ADD;
    end
    if (bus.instr[11:7] == 5'd0) dec_rw = 1'b0;
  end

  logic             valid_q, src_q, rw_q, mr_q, mw_q, ill_q;
  logic [XLEN-1:0]  pc_q, imm_q;
  logic [4:0]       rs1_q, rs2_q, rd_q;
  logic [3:0]       alu_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_c, accept;

  assign in_ready_c = !rst && (!valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      src_q   <= 1'b0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      pc_q    <= bus.pc;
      rs1_q   <= dec_rs1;
      rs2_q   <= bus.instr[24:20];
      rd_q    <= bus.instr[11:7];
      imm_q   <= dec_imm;
      alu_q   <= dec_alu;
      src_q   <= dec_src;
      rw_q    <= dec_rw;
      mr_q    <= dec_mr;
      mw_q    <= dec_mw;
      ill_q   <= dec_ill;
      if (dec_ill && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready        = in_ready_c;
  assign bus.out_valid       = valid_q;
  assign bus.out_pc          = pc_q;
  assign bus.out_rs1         = rs1_q;
  assign bus.out_rs2         = rs2_q;
  assign bus.out_rd          = rd_q;
  assign bus.out_imm         = imm_q;
  assign bus.out_alu_control = alu_q;
  assign bus.out_alu_src     = src_q;
  assign bus.out_reg_write   = rw_q;
  assign bus.out_mem_read    = mr_q;
  assign bus.out_mem_write   = mw_q;
  assign bus.out_illegal     = ill_q;
  assign bus.illegal_count   = cnt_q;
endmodule

// File: tb/tb_rv_decode_stage.sv
// tb/tb_rv_decode_stage.sv - bench for rv_decode_stage: SLT-enabled and SLT-disabled/2-bit-counter instances
module tb_rv_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [31:0] instr = '0, pc = '0;

  always #5 clk = ~clk;

  rv_decode_stage_if #(.XLEN(32), .CNT_W(16)) ifa ();
  rv_decode_stage_if #(.XLEN(32), .CNT_W(2))  ifb ();

  assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
  assign ifa.instr = instr;        assign ifb.instr = instr;
  assign ifa.pc = pc;              assign ifb.pc = pc;
  assign ifa.flush = flush;        assign ifb.flush = flush;
  assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

  rv_decode_stage #(.XLEN(32), .ENABLE_SLT(1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  rv_decode_stage #(.XLEN(32), .ENABLE_SLT(0), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    logic       ill, src, rw, mr, mw;
    logic [3:0] alu;
    logic [31:0] imm;
    logic [4:0] rs1, rs2, rd;
  } dec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference decode written as lookup tables over the instruction-set rules
  logic [9:0] r_key [10];
  logic [3:0] r_code[10];
  initial begin
    r_key = '{10'b0000000_000, 10'b0100000_000, 10'b0000000_111, 10'b0000000_110, 10'b0000000_100,
              10'b0000000_001, 10'b0000000_101, 10'b0100000_101, 10'b0000000_010, 10'b0000000_011};
    r_code = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  end

  function automatic dec_t ref_decode(input logic [31:0] w, input bit slt_en);
    dec_t d;
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    d.ill = 1; d.src = 0; d.rw = 0; d.mr = 0; d.mw = 0; d.alu = 0; d.imm = 0;
    d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7];
    if (op == 7'h33) begin
      d.rw = 1;
      for (int k = 0; k < 10; k++)
        if ({f7, f3} == r_key[k] && (k < 8 || slt_en)) begin d.ill = 0; d.alu = r_code[k]; end
    end else if (op == 7'h13) begin
      d.src = 1; d.rw = 1;
      d.imm = 32'($signed(w[31:20]));
      if (f3 == 0)      begin d.ill = 0; d.alu = 0; end
      else if (f3 == 4) begin d.ill = 0; d.alu = 4; end
      else if (f3 == 6) begin d.ill = 0; d.alu = 3; end
      else if (f3 == 7) begin d.ill = 0; d.alu = 2; end
      else if (f3 == 2 || f3 == 3) begin d.ill = !slt_en; d.alu = (f3 == 2) ? 4'd8 : 4'd9; end
      else begin
        d.imm = 32'(w[24:20]);
        if (f7 == 0) begin d.ill = 0; d.alu = (f3 == 1) ? 4'd5 : 4'd6; end
        else if (f3 == 5 && f7 == 7'h20) begin d.ill = 0; d.alu = 7; end
      end
    end else if (op == 7'h03) begin
      d.src = 1; d.rw = 1; d.mr = 1;
      d.imm = 32'($signed(w[31:20]));
      d.ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    end else if (op == 7'h23) begin
      d.src = 1; d.mw = 1;
      d.imm = 32'($signed({w[31:25], w[11:7]}));
      d.ill = (f3 > 2);
    end else if (op == 7'h37) begin
      d.ill = 0; d.src = 1; d.rw = 1; d.rs1 = 0;
      d.imm = {w[31:12], 12'h000};
    end
    if (d.ill) begin d.rw = 0; d.mr = 0; d.mw = 0; d.alu = 0; end
    if (d.rd == 0) d.rw = 0;
    return d;
  endfunction

  // model of the pipeline slot and counters
  logic m_valid = 0;
  logic [31:0] m_pc;
  dec_t m_a, m_b;
  int m_cnt_a = 0, m_cnt_b = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 0; m_cnt_a <= 0; m_cnt_b <= 0;
    end else if (flush) begin
      m_valid <= 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1;
      m_pc <= pc;
      m_a <= ref_decode(instr, 1);
      m_b <= ref_decode(instr, 0);
      if (ref_decode(instr, 1).ill) m_cnt_a <= (m_cnt_a == 65535) ? m_cnt_a : m_cnt_a + 1;
      if (ref_decode(instr, 0).ill) m_cnt_b <= (m_cnt_b == 3) ? m_cnt_b : m_cnt_b + 1;
    end else if (out_ready) begin
      m_valid <= 0;
    end
  end

  task automatic cmp_dec(input string tag, input dec_t act, input dec_t e);
    chk({tag, ".illegal"}, act.ill, e.ill);
    chk({tag, ".alu"}, act.alu, e.alu);
    chk({tag, ".reg_write"}, act.rw, e.rw);
    chk({tag, ".mem_read"}, act.mr, e.mr);
    chk({tag, ".mem_write"}, act.mw, e.mw);
    chk({tag, ".rs1"}, act.rs1, e.rs1);
    chk({tag, ".rs2"}, act.rs2, e.rs2);
    chk({tag, ".rd"}, act.rd, e.rd);
    if (!e.ill) begin
      chk({tag, ".alu_src"}, act.src, e.src);
      chk({tag, ".imm"}, act.imm, e.imm);
    end
  endtask

  dec_t act_a, act_b;
  always_comb begin
    act_a.ill = ifa.out_illegal; act_a.src = ifa.out_alu_src; act_a.rw = ifa.out_reg_write;
    act_a.mr = ifa.out_mem_read; act_a.mw = ifa.out_mem_write; act_a.alu = ifa.out_alu_control;
    act_a.imm = ifa.out_imm; act_a.rs1 = ifa.out_rs1; act_a.rs2 = ifa.out_rs2; act_a.rd = ifa.out_rd;
    act_b.ill = ifb.out_illegal; act_b.src = ifb.out_alu_src; act_b.rw = ifb.out_reg_write;
    act_b.mr = ifb.out_mem_read; act_b.mw = ifb.out_mem_write; act_b.alu = ifb.out_alu_control;
    act_b.imm = ifb.out_imm; act_b.rs1 = ifb.out_rs1; act_b.rs2 = ifb.out_rs2; act_b.rd = ifb.out_rd;
  end

  always @(negedge clk) begin
    chk("a.in_ready", ifa.in_ready, !rst && (!m_valid || out_ready));
    chk("b.in_ready", ifb.in_ready, !rst && (!m_valid || out_ready));
    chk("a.out_valid", ifa.out_valid, m_valid);
    chk("b.out_valid", ifb.out_valid, m_valid);
    chk("a.illegal_count", ifa.illegal_count, m_cnt_a);
    chk("b.illegal_count", ifb.illegal_count, m_cnt_b);
    if (m_valid) begin
      chk("a.out_pc", ifa.out_pc, m_pc);
      chk("b.out_pc", ifb.out_pc, m_pc);
      cmp_dec("a", act_a, m_a);
      cmp_dec("b", act_b, m_b);
    end
  end

  task automatic cyc(input logic v, input logic [31:0] i, input logic [31:0] p,
                     input logic fl, input logic ordy);
    in_valid = v; instr = i; pc = p; flush = fl; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 6))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h37;
      5: w[6:0] = ($urandom_range(0, 1) == 0) ? 7'h33 : 7'h13;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0, 1: w[31:25] = 7'h00;
      2: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    dec_t d;
    d = ref_decode(32'h002081B3, 1);
    chk("model.add", {d.ill, d.alu, d.rs1, d.rs2, d.rd, d.rw}, {1'b0, 4'd0, 5'd1, 5'd2, 5'd3, 1'b1});
    d = ref_decode(32'hFFC0A203, 1);
    chk("model.lw_imm", d.imm, 32'hFFFFFFFC);
    d = ref_decode(32'h0020A1B3, 0);
    chk("model.slt_off", {d.ill, d.rw}, 2'b10);
    d = ref_decode(32'h4030D093, 1);
    chk("model.srai", {d.alu, d.imm}, {4'd7, 32'd3});

    rst = 1;
    cyc(1, 32'h002081B3, 32'h0, 0, 1);
    chk("rst.in_ready", ifa.in_ready, 0);
    cyc(0, 0, 0, 0, 1);
    chk("rst.out_valid", ifa.out_valid, 0);
    chk("rst.out_imm", ifa.out_imm, 0);
    chk("rst.count", ifa.illegal_count, 0);
    rst = 0;

    cyc(1, 32'h002081B3, 32'h100, 0, 1);
    chk("add.valid", ifa.out_valid, 1);
    chk("add.fields", {ifa.out_alu_control, ifa.out_rs1, ifa.out_rs2, ifa.out_rd, ifa.out_reg_write, ifa.out_alu_src},
        {4'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0});
    chk("add.pc", ifa.out_pc, 32'h100);
    cyc(1, 32'hFFF00293, 32'h104, 0, 1);
    chk("addi.imm", ifa.out_imm, 32'hFFFFFFFF);
    chk("addi.src_rw", {ifa.out_alu_src, ifa.out_reg_write}, 2'b11);
    cyc(1, 32'h4030D093, 32'h108, 0, 1);
    chk("srai", {ifa.out_alu_control, ifa.out_imm}, {4'd7, 32'd3});
    cyc(1, 32'h0020A423, 32'h10C, 0, 1);
    chk("sw", {ifa.out_imm, ifa.out_mem_write, ifa.out_reg_write}, {32'd8, 1'b1, 1'b0});
    cyc(1, 32'hFFC0A203, 32'h110, 0, 1);
    chk("lw", {ifa.out_imm, ifa.out_mem_read}, {32'hFFFFFFFC, 1'b1});

    for (int k = 0; k < 3; k++) begin
      cyc(1, 32'h002081B3, 32'h200, 0, 0);
      chk("stall.in_ready", ifa.in_ready, 0);
      chk("stall.hold", {ifa.out_valid, ifa.out_pc, ifa.out_imm, ifa.out_mem_read}, {1'b1, 32'h110, 32'hFFFFFFFC, 1'b1});
    end
    cyc(1, 32'h002081B3, 32'h200, 0, 1);
    chk("stall.release_pc", ifa.out_pc, 32'h200);

    cyc(1, 32'hFFFFFFFF, 32'h204, 0, 1);
    cyc(1, 32'h0020A1B3, 32'h208, 0, 1);
    chk("slt_off", {ifb.out_illegal, ifb.out_reg_write, ifb.illegal_count}, {1'b1, 1'b0, 2'd2});
    chk("slt_on", {ifa.out_illegal, ifa.out_alu_control, ifa.illegal_count}, {1'b0, 4'd8, 16'd1});
    for (int k = 0; k < 3; k++) cyc(1, 32'hFFFFFFFF, 32'h20C, 0, 1);
    chk("sat.b", ifb.illegal_count, 3);
    chk("cnt.a", ifa.illegal_count, 4);

    cyc(1, 32'hFFFFFFFF, 32'h300, 1, 1);
    chk("flush.valid", ifa.out_valid, 0);
    chk("flush.count", ifa.illegal_count, 4);

    cyc(1, 32'h002081B3, 32'h400, 0, 1);
    rst = 1;
    cyc(1, 32'h002081B3, 32'h404, 0, 1);
    chk("midrst", {ifa.out_valid, ifa.out_pc, ifa.out_imm, ifa.illegal_count, ifa.out_reg_write}, 0);
    rst = 0;

    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      cyc($urandom_range(0, 9) < 7, rand_instr(), {$urandom, 2'b00} & 32'hFFFFFFFC,
          $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end
    rst = 0;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered RV32I decode/control stage; next generation of the combinational control decoder.
- Sits between fetch and execute. Accepts one instruction plus its PC per cycle over a valid/ready handshake.
- Produces registered control, register indices and sign-extended immediate, with 1-cycle latency.
- Adds over the previous decoder: load/store/LUI decode, XORI and optional SLT/SLTU, illegal-instruction detection with a saturating counter, backpressure and flush.

Parameters:
- XLEN, 32: datapath width of pc and out_imm; must be >= 32.
- ENABLE_SLT, 1: when 1, SLT/SLTU/SLTI/SLTIU are decoded; when 0 they are illegal.
- CNT_W, 16: width of illegal_count.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction/pc valid
- in_ready  out  1  stage can accept this cycle
- instr  in  32  instruction word
- pc  in  XLEN  instruction address
- flush  in  1  kill held and incoming instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts bundle
- out_pc  out  XLEN  registered pc
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_imm  out  XLEN  sign-extended immediate
- out_alu_control  out  4  ALU op code
- out_alu_src  out  1  1 = immediate operand B
- out_reg_write, out_mem_read, out_mem_write  out  1 each
- out_illegal  out  1  bundle is an illegal instruction
- illegal_count  out  CNT_W  saturating illegal-instruction count

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: all out_* registers and illegal_count are 0; in_ready is 0 while rst is high.
- Handshake: in_ready = !rst && (!out_valid || out_ready). Accept = in_valid && in_ready.
- On accept: bundle is registered and out_valid=1 next cycle (latency 1). Back-to-back throughput is 1 per cycle.
- Consumed without accept: out_valid=0 next cycle.
- Stall: out_valid && !out_ready holds every out_* stable.
- Flush has priority: next cycle out_valid=0, the incoming accept is discarded, and illegal_count does not increment.
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- R-type (0110011): {funct7,funct3} maps per the codes above. SLT is 0000000/010; SLTU is 0000000/011. Any other combination is illegal.
- I-ALU (0010011):
  - funct3 000 ADDI, 100 XORI, 110 ORI, 111 ANDI, 010 SLTI, 011 SLTIU.
  - 001 SLLI requires funct7=0000000.
  - 101 requires funct7=0000000 (SRLI) or 0100000 (SRAI); otherwise illegal.
  - alu_src=1.
- LOAD (0000011): funct3 in {000,001,010,100,101} is legal. ALU ADD, alu_src=1, mem_read=1, reg_write=1.
- STORE (0100011): funct3 in {000,001,010} is legal. ALU ADD, alu_src=1, mem_write=1, reg_write=0.
- LUI (0110111): out_rs1=0, ALU ADD, alu_src=1, reg_write=1.
- Any other opcode is illegal.
- Immediates:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25],instr[11:7]}).
  - U: sext({instr[31:12],12'b0}).
  - Shifts: {0,instr[24:20]}.
  - R-type: 0.
  - All sign-extension is to XLEN.
- Illegal bundle: out_illegal=1; reg_write, mem_read, mem_write = 0; alu_control=0000.
- rd=x0 forces out_reg_write=0.
- rs1/rs2/rd are always instr[19:15], [24:20], [11:7], except the LUI rs1 override.
- illegal_count: +1 on each non-flushed accept of an illegal instruction; saturates at 2^CNT_W-1.
- Reset mid-stream: out_valid drops the next cycle, the count clears, and no pending bundle survives.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), pc=0x100 accepted -> next cycle out_valid=1, alu 0000, rs1=1, rs2=2, rd=3, reg_write=1, alu_src=0, out_pc=0x100.
- ADDI x5,x0,-1 (0xFFF00293) -> out_imm=0xFFFFFFFF, alu_src=1, reg_write=1; SRAI x1,x1,3 (0x4030D093) -> alu 0111, imm=3.
- SW x2,8(x1) (0x0020A423) -> imm=8, mem_write=1, reg_write=0; LW x4,-4(x1) (0xFFC0A203) -> imm=0xFFFFFFFC, mem_read=1.
- out_ready=0 for 3 cycles with a bundle held -> in_ready=0 and outputs stable; a new instruction is accepted the cycle out_ready returns to 1.
- 0xFFFFFFFF, then SLT (0x0020A1B3) with ENABLE_SLT=0 -> out_illegal=1, reg_write=0, illegal_count=2; with CNT_W=2, 5 illegal instructions give illegal_count=3.
- Flush while out_valid=1 and an illegal instruction is arriving -> out_valid=0 next cycle and count unchanged; rst asserted mid-stream -> all outputs 0 the next cycle.
